// File: rtl/seq_det_pkg.sv
// Shared FSM encodings and power-on pattern defaults for the configurable
// sequence detector and its frame controller.
package seq_det_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam logic [4:0] DEFAULT_PATTERN = 5'b10110;
  localparam int         DEFAULT_PLEN    = 5;

endpackage

// File: rtl/pattern_matcher.sv
// Programmable bit-serial matcher: history shift register, fill counter and
// masked compare. Define SEQ_FRAME_OVERLAP_EN for overlapping detection.
module pattern_matcher
  import seq_det_pkg::*;
#(
  parameter int PAT_W = 5,
  parameter int LW    = $clog2(PAT_W + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LW-1:0]    cfg_len,
  input  logic             clear,
  input  logic             shift,
  input  logic             bit_data,
  output logic             match
);

  localparam logic [LW-1:0] RST_PLEN =
    LW'((DEFAULT_PLEN > PAT_W) ? PAT_W : DEFAULT_PLEN);

  logic [PAT_W-1:0] pattern;
  logic [PAT_W-1:0] history;
  logic [PAT_W-1:0] history_next;
  logic [PAT_W-1:0] mask;
  logic [LW-1:0]    plen;
  logic [LW-1:0]    fill;
  logic [LW-1:0]    fill_next;
  logic [LW-1:0]    len_clamped;

  // A zero or oversized length means "use the full pattern width".
  always_comb begin
    len_clamped = cfg_len;
    if (cfg_len == '0 || int'(cfg_len) > PAT_W) len_clamped = LW'(PAT_W);
  end

  always_comb begin
    mask = '0;
    for (int i = 0; i < PAT_W; i++) mask[i] = (i < int'(plen));
  end

  assign history_next = PAT_W'({history, bit_data});
  assign fill_next    = (fill == plen) ? plen : fill + 1'b1;
  assign match        = shift && (fill_next == plen) &&
                        (((history_next ^ pattern) & mask) == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      pattern <= PAT_W'(DEFAULT_PATTERN);
      plen    <= RST_PLEN;
      history <= '0;
      fill    <= '0;
    end else begin
      if (load) begin
        pattern <= cfg_pattern;
        plen    <= len_clamped;
      end
      if (clear) begin
        history <= '0;
        fill    <= '0;
      end else if (shift) begin
        history <= history_next;
`ifdef SEQ_FRAME_OVERLAP_EN
        fill    <= fill_next;
`else
        fill    <= match ? '0 : fill_next;
`endif
      end
    end
  end

endmodule

// File: rtl/seq_frame_ctrl.sv
// Frame controller: IDLE/RUN/DONE sequencing, bit handshake, frame counter and
// saturating match counter. SEQ_FRAME_OVERLAP_EN selects overlapping matches.
module seq_frame_ctrl
  import seq_det_pkg::*;
#(
  parameter int PAT_W = 5,
  parameter int LEN_W = 8,
  parameter int CNT_W = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       cfg_load,
  input  logic [PAT_W-1:0]           cfg_pattern,
  input  logic [$clog2(PAT_W+1)-1:0] cfg_len,
  input  logic                       start,
  input  logic [LEN_W-1:0]           frame_len,
  input  logic                       bit_valid,
  input  logic                       bit_data,
  output logic                       bit_ready,
  output logic                       busy,
  output logic                       done,
  output logic                       match_pulse,
  output logic [CNT_W-1:0]           match_count,
  output logic [1:0]                 state
);

  // Handshake: a bit transfers on a rising edge where bit_valid and bit_ready
  // are both high; bit_ready depends only on state, never on bit_valid.
  state_t           state_q, state_d;
  logic [LEN_W-1:0] remaining;
  logic             load, go, xfer, match;

  assign load      = cfg_load && (state_q == IDLE);
  assign go        = start && (state_q == IDLE);
  assign bit_ready = (state_q == RUN);
  assign busy      = (state_q == RUN) || (state_q == DONE);
  assign done      = (state_q == DONE);
  assign xfer      = bit_valid && bit_ready;
  assign state     = state_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = (frame_len != '0) ? RUN : DONE;
      RUN:  if (xfer && remaining == LEN_W'(1)) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  pattern_matcher #(.PAT_W(PAT_W)) u_matcher (
    .clk         (clk),
    .reset       (reset),
    .load        (load),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .clear       (go),
    .shift       (xfer),
    .bit_data    (bit_data),
    .match       (match)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      remaining   <= '0;
      match_count <= '0;
      match_pulse <= 1'b0;
    end else begin
      state_q     <= state_d;
      match_pulse <= match;
      if (go) begin
        remaining   <= frame_len;
        match_count <= '0;
      end else if (xfer) begin
        remaining <= remaining - 1'b1;
        if (match && match_count != '1) match_count <= match_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seq_frame_ctrl.sv
// Directed bench for seq_frame_ctrl; a second instance with CNT_W=2 shares the
// stimulus to exercise counter saturation. Honours SEQ_FRAME_OVERLAP_EN.
module tb_seq_frame_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cfg_load = 1'b0;
  logic [4:0] cfg_pattern = '0;
  logic [2:0] cfg_len = '0;
  logic       start = 1'b0;
  logic [7:0] frame_len = '0;
  logic       bit_valid = 1'b0;
  logic       bit_data = 1'b0;
  logic       bit_ready, busy, done, match_pulse;
  logic [7:0] match_count;
  logic [1:0] state;
  logic       bit_ready2, busy2, done2, match_pulse2;
  logic [1:0] match_count2;
  logic [1:0] state2;

  int compared = 0;
  int mismatched = 0;

`ifdef SEQ_FRAME_OVERLAP_EN
  localparam int        EXP_DEF_CNT  = 2;
  localparam logic [15:0] EXP_DEF_MASK = 16'h0090;
`else
  localparam int        EXP_DEF_CNT  = 1;
  localparam logic [15:0] EXP_DEF_MASK = 16'h0010;
`endif

  seq_frame_ctrl dut (
    .clk(clk), .reset(reset), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .start(start), .frame_len(frame_len),
    .bit_valid(bit_valid), .bit_data(bit_data), .bit_ready(bit_ready),
    .busy(busy), .done(done), .match_pulse(match_pulse),
    .match_count(match_count), .state(state)
  );

  seq_frame_ctrl #(.CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .start(start), .frame_len(frame_len),
    .bit_valid(bit_valid), .bit_data(bit_data), .bit_ready(bit_ready2),
    .busy(busy2), .done(done2), .match_pulse(match_pulse2),
    .match_count(match_count2), .state(state2)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          xfers;
    logic [15:0] mask;
    int          pulses2;
    int          gaps;
    int          early_done;
    int          spurious;
    int          timeout;
    logic        done_end, busy_end, ready_end;
    logic [7:0]  cnt_end;
    logic [1:0]  cnt2_end;
    logic        done_idle, ready_idle;
    logic [1:0]  state_idle;
    logic [7:0]  cnt_idle;
  } frame_res_t;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [4:0] pat, input logic [2:0] len);
    cfg_load = 1'b1; cfg_pattern = pat; cfg_len = len;
    step();
    cfg_load = 1'b0;
  endtask

  // Starts a frame of n bits and streams bits[k] as the k-th bit.
  task automatic drive_frame(input int n, input logic [15:0] bits,
                             input bit toggle, input bit noise,
                             output frame_res_t r);
    int k = 0;
    int cyc = 0;
    logic xfer_now;
    r = '{default: 0};
    start = 1'b1; frame_len = 8'(n);
    step();
    start = 1'b0;
    while (k < n && cyc < 64) begin
      bit_valid = toggle ? (cyc % 2 == 0) : 1'b1;
      bit_data  = bits[k];
      if (noise) begin
        start = 1'b1; frame_len = 8'd2;
        cfg_load = 1'b1; cfg_pattern = 5'b00001; cfg_len = 3'd1;
      end
      if (bit_ready !== 1'b1) r.gaps++;
      xfer_now = bit_valid & bit_ready;
      step();
      cyc++;
      if (match_pulse2 === 1'b1) r.pulses2++;
      if (xfer_now) begin
        if (match_pulse === 1'b1) r.mask[k] = 1'b1;
        k++;
        r.xfers++;
      end else if (match_pulse === 1'b1) begin
        r.spurious++;
      end
      if (k < n && done === 1'b1) r.early_done++;
    end
    start = 1'b0; cfg_load = 1'b0;
    if (k < n) r.timeout = 1;
    r.done_end = done; r.busy_end = busy; r.ready_end = bit_ready;
    r.cnt_end = match_count; r.cnt2_end = match_count2;
    bit_valid = 1'b1;
    step();
    r.done_idle = done; r.ready_idle = bit_ready;
    r.state_idle = state; r.cnt_idle = match_count;
    bit_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(); step();
    compared++;
    if ({state, busy, bit_ready, done, match_pulse} !== 6'b0) begin
      mismatched++;
      $display("FAIL reset_outputs: got state=%0d busy=%b ready=%b done=%b pulse=%b want all 0",
               state, busy, bit_ready, done, match_pulse);
    end
    compared++;
    if (match_count !== 8'd0) begin
      mismatched++; $display("FAIL reset_count: got %0d want 0", match_count);
    end
    reset = 1'b0;
    step();
    compared++;
    if (state !== 2'b00) begin
      mismatched++; $display("FAIL reset_idle: got state=%0d want 0", state);
    end
  endtask

  task automatic test_default_pattern(input string tag);
    frame_res_t r;
    drive_frame(8, 16'h006D, 1'b0, 1'b0, r);
    compared++;
    if (r.timeout != 0 || r.xfers != 8) begin
      mismatched++; $display("FAIL %s_xfers: got %0d want 8", tag, r.xfers);
    end
    compared++;
    if (r.mask !== EXP_DEF_MASK || r.spurious != 0) begin
      mismatched++;
      $display("FAIL %s_pulses: got mask=%h spurious=%0d want mask=%h spurious=0",
               tag, r.mask, r.spurious, EXP_DEF_MASK);
    end
    compared++;
    if ({r.done_end, r.busy_end, r.ready_end} !== 3'b110 || r.early_done != 0) begin
      mismatched++;
      $display("FAIL %s_done: got done=%b busy=%b ready=%b early=%0d want 1 1 0 0",
               tag, r.done_end, r.busy_end, r.ready_end, r.early_done);
    end
    compared++;
    if (r.cnt_end !== 8'(EXP_DEF_CNT)) begin
      mismatched++; $display("FAIL %s_count: got %0d want %0d", tag, r.cnt_end, EXP_DEF_CNT);
    end
    compared++;
    if (r.done_idle !== 1'b0 || r.state_idle !== 2'b00 || r.cnt_idle !== 8'(EXP_DEF_CNT)) begin
      mismatched++;
      $display("FAIL %s_after: got done=%b state=%0d count=%0d want 0 0 %0d",
               tag, r.done_idle, r.state_idle, r.cnt_idle, EXP_DEF_CNT);
    end
  endtask

  task automatic test_toggle_valid();
    frame_res_t r;
    do_load(5'b00011, 3'd3);
    drive_frame(6, 16'h0036, 1'b1, 1'b0, r);
    compared++;
    if (r.cnt_end !== 8'd2 || r.mask !== 16'h0024) begin
      mismatched++;
      $display("FAIL toggle_count: got count=%0d mask=%h want 2 mask=0024", r.cnt_end, r.mask);
    end
    compared++;
    if (r.gaps != 0 || r.xfers != 6 || r.timeout != 0) begin
      mismatched++;
      $display("FAIL toggle_ready: got gaps=%0d xfers=%0d want 0 6", r.gaps, r.xfers);
    end
    compared++;
    if (r.done_end !== 1'b1 || r.ready_idle !== 1'b0) begin
      mismatched++;
      $display("FAIL toggle_done: got done=%b idle_ready=%b want 1 0", r.done_end, r.ready_idle);
    end
  endtask

  task automatic test_saturation();
    frame_res_t r;
    do_load(5'b00001, 3'd1);
    drive_frame(6, 16'h003F, 1'b0, 1'b0, r);
    compared++;
    if (r.cnt2_end !== 2'd3) begin
      mismatched++; $display("FAIL sat_count2: got %0d want 3", r.cnt2_end);
    end
    compared++;
    if (r.pulses2 != 6 || r.mask !== 16'h003F) begin
      mismatched++;
      $display("FAIL sat_pulses: got pulses2=%0d mask=%h want 6 003f", r.pulses2, r.mask);
    end
    compared++;
    if (r.cnt_end !== 8'd6) begin
      mismatched++; $display("FAIL sat_count8: got %0d want 6", r.cnt_end);
    end
  endtask

  task automatic test_zero_len();
    logic [1:0] st;
    logic [7:0] cnt;
    logic       d, b, rd, d2;
    start = 1'b1; frame_len = 8'd0; bit_valid = 1'b1; bit_data = 1'b1;
    step();
    start = 1'b0;
    st = state; cnt = match_count; d = done; b = busy; rd = bit_ready;
    step();
    d2 = done;
    bit_valid = 1'b0;
    compared++;
    if (st !== 2'b10 || d !== 1'b1 || b !== 1'b1 || rd !== 1'b0) begin
      mismatched++;
      $display("FAIL zero_done: got state=%0d done=%b busy=%b ready=%b want 2 1 1 0", st, d, b, rd);
    end
    compared++;
    if (cnt !== 8'd0) begin
      mismatched++; $display("FAIL zero_count: got %0d want 0", cnt);
    end
    compared++;
    if (d2 !== 1'b0 || state !== 2'b00) begin
      mismatched++; $display("FAIL zero_pulse: got done=%b state=%0d want 0 0", d2, state);
    end
  endtask

  task automatic test_ignore_in_run();
    frame_res_t r;
    do_load(5'b10110, 3'd5);
    drive_frame(5, 16'h000D, 1'b0, 1'b1, r);
    compared++;
    if (r.xfers != 5 || r.early_done != 0 || r.done_end !== 1'b1) begin
      mismatched++;
      $display("FAIL ignore_len: got xfers=%0d early=%0d done=%b want 5 0 1",
               r.xfers, r.early_done, r.done_end);
    end
    compared++;
    if (r.cnt_end !== 8'd1 || r.mask !== 16'h0010) begin
      mismatched++;
      $display("FAIL ignore_pattern: got count=%0d mask=%h want 1 0010", r.cnt_end, r.mask);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic seen_done = 1'b0;
    do_load(5'b00001, 3'd1);
    start = 1'b1; frame_len = 8'd8;
    step();
    start = 1'b0;
    bit_valid = 1'b1; bit_data = 1'b1;
    repeat (3) step();
    compared++;
    if (match_count !== 8'd3 || state !== 2'b01) begin
      mismatched++;
      $display("FAIL abort_pre: got count=%0d state=%0d want 3 1", match_count, state);
    end
    reset = 1'b1; bit_valid = 1'b0;
    step();
    seen_done = done;
    compared++;
    if (state !== 2'b00 || busy !== 1'b0 || match_count !== 8'd0) begin
      mismatched++;
      $display("FAIL abort_state: got state=%0d busy=%b count=%0d want 0 0 0",
               state, busy, match_count);
    end
    reset = 1'b0;
    repeat (2) begin
      step();
      seen_done = seen_done | done;
    end
    compared++;
    if (seen_done !== 1'b0) begin
      mismatched++; $display("FAIL abort_done: got done seen=%b want 0", seen_done);
    end
    test_default_pattern("abort_default");
  endtask

  task automatic test_len_clamp();
    frame_res_t r;
    do_load(5'b01101, 3'd0);
    drive_frame(5, 16'h0016, 1'b0, 1'b0, r);
    compared++;
    if (r.cnt_end !== 8'd1 || r.mask !== 16'h0010) begin
      mismatched++;
      $display("FAIL clamp_zero: got count=%0d mask=%h want 1 0010", r.cnt_end, r.mask);
    end
    do_load(5'b01101, 3'd7);
    drive_frame(5, 16'h0016, 1'b0, 1'b0, r);
    compared++;
    if (r.cnt_end !== 8'd1 || r.mask !== 16'h0010) begin
      mismatched++;
      $display("FAIL clamp_big: got count=%0d mask=%h want 1 0010", r.cnt_end, r.mask);
    end
  endtask

  initial begin
    test_reset();
    test_default_pattern("default");
    test_toggle_valid();
    test_saturation();
    test_zero_len();
    test_ignore_in_run();
    test_reset_mid_frame();
    test_len_clamp();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
